// File: rtl/lmem_stream_reader.sv
// Streams `len` consecutive LMEM words starting at `base_addr` onto a valid/ready
// interface, hiding the RAM's one-cycle read latency behind a 2-entry output buffer.
module lmem_stream_reader #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] ONE_WORD = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_nx;
    logic [ADDR_WIDTH-1:0]   addr_ptr;
    logic [ADDR_WIDTH:0]     remaining_issue;
    logic [ADDR_WIDTH:0]     remaining_out;
    logic                    pend;
    logic [DATA_WIDTH-1:0]   fifo_mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              occ;
    logic [2:0]              credit_used;
    logic                    pop;
    logic                    issue;
    logic                    accept;
    logic                    last_pop;

    assign out_valid   = (occ != 2'd0);
    assign out_data    = fifo_mem[rd_ptr];
    assign mem_addr    = addr_ptr;
    assign pop         = out_valid && out_ready;
    assign accept      = (state == S_IDLE) && start;
    assign last_pop    = (state == S_RUN) && pop && (remaining_out == ONE_WORD);

    // A read in flight already owns a FIFO slot; a same-cycle pop frees one.
    assign credit_used = {1'b0, occ} + {2'b00, pend};
    assign issue       = (state == S_RUN) && (remaining_issue != '0) &&
                         ((credit_used < 3'd2) || ((credit_used == 3'd2) && pop));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_pop) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // An empty command leaves the address bus untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_ptr        <= '0;
            remaining_issue <= '0;
            remaining_out   <= '0;
            pend            <= 1'b0;
        end else begin
            pend <= issue;
            if (accept) begin
                if (len != '0) begin
                    addr_ptr <= base_addr;
                end
                remaining_issue <= len;
                remaining_out   <= len;
            end else begin
                if (issue) begin
                    addr_ptr        <= addr_ptr + 1'b1;
                    remaining_issue <= remaining_issue - ONE_WORD;
                end
                if (pop) begin
                    remaining_out <= remaining_out - ONE_WORD;
                end
            end
        end
    end

    // NOTE: the two buffer entries are reset (unlike a RAM) because out_data
    // is read straight from the head entry and must be 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (pend) begin
                fifo_mem[wr_ptr] <= mem_q;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({pend, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule
